// File: rtl/taillight_monitor_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : taillight_monitor_if
// Brief    : Lamp sample bus and monitor result bus for taillight_monitor.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface taillight_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             tick;
    logic             LA;
    logic             LB;
    logic             LC;
    logic             RA;
    logic             RB;
    logic             RC;
    logic             clr_counts;
    logic [2:0]       mode;
    logic             seq_err;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] left_sweeps;
    logic [CNT_W-1:0] right_sweeps;

    modport master (
        output tick, LA, LB, LC, RA, RB, RC, clr_counts,
        input  mode, seq_err, err_count, left_sweeps, right_sweeps
    );

    modport slave (
        input  tick, LA, LB, LC, RA, RB, RC, clr_counts,
        output mode, seq_err, err_count, left_sweeps, right_sweeps
    );
endinterface
`default_nettype wire

// File: rtl/taillight_monitor.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : taillight_monitor
// Brief    : Tracks tail-light lamp sequences, decodes mode, counts sweeps/errors.
// Revision : 1.0
// ---------------------------------------------------------------------------
module taillight_monitor #(
    parameter int CNT_W = 8
) (
    input  wire logic        clk,
    input  wire logic        Reset,
    taillight_monitor_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_L1      = 4'd1,
        S_L2      = 4'd2,
        S_L3      = 4'd3,
        S_R1      = 4'd4,
        S_R2      = 4'd5,
        S_R3      = 4'd6,
        S_ALL     = 4'd7,
        S_BRAKE   = 4'd8,
        S_HAZ_ON  = 4'd9,
        S_HAZ_OFF = 4'd10
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [2:0]       r_mode;
    logic             r_seq_err;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_left_sweeps;
    logic [CNT_W-1:0] r_right_sweeps;

    state_t           w_next;
    logic             w_err;
    logic             w_left_done;
    logic             w_right_done;
    logic [5:0]       w_pat;

    function automatic logic [2:0] mode_of(input state_t s);
        case (s)
            S_L1, S_L2, S_L3:    mode_of = 3'd1;
            S_R1, S_R2, S_R3:    mode_of = 3'd2;
            S_HAZ_ON, S_HAZ_OFF: mode_of = 3'd3;
            S_BRAKE:             mode_of = 3'd4;
            S_ALL:               mode_of = 3'd5;
            default:             mode_of = 3'd0;
        endcase
    endfunction

    assign w_pat = {bus.LC, bus.LB, bus.LA, bus.RC, bus.RB, bus.RA};

    always_comb begin
        w_next       = r_state;
        w_err        = 1'b0;
        w_left_done  = 1'b0;
        w_right_done = 1'b0;
        case (w_pat)
            6'b000_000: begin
                case (r_state)
                    S_ALL, S_HAZ_ON: w_next = S_HAZ_OFF;
                    S_L3: begin
                        w_next      = S_IDLE;
                        w_left_done = 1'b1;
                    end
                    S_R3: begin
                        w_next       = S_IDLE;
                        w_right_done = 1'b1;
                    end
                    S_L1, S_L2, S_R1, S_R2: begin
                        w_next = S_IDLE;
                        w_err  = 1'b1;
                    end
                    default: w_next = S_IDLE;
                endcase
            end
            // Step patterns always resync to their own state, flagging a skip.
            6'b001_000: begin w_next = S_L1; w_err = (r_state != S_IDLE); end
            6'b011_000: begin w_next = S_L2; w_err = (r_state != S_L1);   end
            6'b111_000: begin w_next = S_L3; w_err = (r_state != S_L2);   end
            6'b000_001: begin w_next = S_R1; w_err = (r_state != S_IDLE); end
            6'b000_011: begin w_next = S_R2; w_err = (r_state != S_R1);   end
            6'b000_111: begin w_next = S_R3; w_err = (r_state != S_R2);   end
            6'b111_111: begin
                case (r_state)
                    S_IDLE:                   w_next = S_ALL;
                    S_ALL, S_BRAKE, S_HAZ_ON: w_next = S_BRAKE;
                    S_HAZ_OFF:                w_next = S_HAZ_ON;
                    default: begin
                        w_next = S_ALL;
                        w_err  = 1'b1;
                    end
                endcase
            end
            default: begin
                w_next = S_IDLE;
                w_err  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state        <= S_IDLE;
            r_mode         <= 3'd0;
            r_seq_err      <= 1'b0;
            r_err_count    <= '0;
            r_left_sweeps  <= '0;
            r_right_sweeps <= '0;
        end else begin
            r_seq_err <= 1'b0;
            if (bus.tick) begin
                r_state   <= w_next;
                r_mode    <= mode_of(w_next);
                r_seq_err <= w_err;
            end
            if (bus.clr_counts) begin
                r_err_count    <= '0;
                r_left_sweeps  <= '0;
                r_right_sweeps <= '0;
            end else if (bus.tick) begin
                if (w_err && r_err_count != c_cnt_max)
                    r_err_count <= r_err_count + c_cnt_one;
                if (w_left_done && r_left_sweeps != c_cnt_max)
                    r_left_sweeps <= r_left_sweeps + c_cnt_one;
                if (w_right_done && r_right_sweeps != c_cnt_max)
                    r_right_sweeps <= r_right_sweeps + c_cnt_one;
            end
        end
    end

    assign bus.mode         = r_mode;
    assign bus.seq_err      = r_seq_err;
    assign bus.err_count    = r_err_count;
    assign bus.left_sweeps  = r_left_sweeps;
    assign bus.right_sweeps = r_right_sweeps;

endmodule
`default_nettype wire

// File: doc/taillight_monitor.md
Name: taillight_monitor

Overview:
- Receive-side checker for the tail-light FSM lamp outputs (LA, LB, LC, RA, RB, RC).
- Samples the six lamp lines on each lamp-update strobe and tracks the expected next pattern.
- Decodes the active mode (left, right, hazard, brake), counts completed sweeps, and flags illegal or out-of-order lamp sequences.
- Used in the same divided-clock domain as the FSM, both for bench self-checking and as an on-chip health monitor.

Parameters:
- CNT_W, 8, width of every saturating counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- Reset  in  1  synchronous, active-low reset. Reset=0 at a rising clk edge resets the block.
- tick  in  1  lamp-update strobe. Lamps are sampled only on edges where tick=1.
- LA, LB, LC  in  1 each  left lamps.
- RA, RB, RC  in  1 each  right lamps.
- clr_counts  in  1  synchronous clear of all counters.
- mode  out  3  decoded mode: 0 IDLE, 1 LEFT, 2 RIGHT, 3 HAZARD, 4 BRAKE, 5 PENDING.
- seq_err  out  1  one-cycle pulse on an illegal or out-of-order sample.
- err_count  out  CNT_W  saturating count of seq_err pulses.
- left_sweeps  out  CNT_W  saturating count of completed left sweeps.
- right_sweeps  out  CNT_W  saturating count of completed right sweeps.

Behaviour:
- Sample definitions: L={LC,LB,LA}, R={RC,RB,RA}.
- Legal patterns (L/R):
  - 000/000 = OFF
  - 001/000, 011/000, 111/000 = left steps 1-3
  - 000/001, 000/011, 000/111 = right steps 1-3
  - 111/111 = ALL
  - Any other pattern is illegal.
- Reset (Reset=0 at an edge): state=S_IDLE, mode=0, seq_err=0, all counters=0. Reset overrides tick and clr_counts. Reset in mid-sweep discards the sweep; nothing is counted.
- States: S_IDLE, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_ALL, S_BRAKE, S_HAZ_ON, S_HAZ_OFF.
- mode encoding from state (Moore, registered state):
  - S_IDLE → 0
  - S_L* → 1
  - S_R* → 2
  - S_HAZ_* → 3
  - S_BRAKE → 4
  - S_ALL → 5
- Timing: mode changes in the cycle after the sampling edge. seq_err is registered at the sampling edge and is high for exactly one clk.
- When tick=0: no state change, seq_err=0.
- Transitions on tick=1:
  - OFF:
    - S_ALL or S_HAZ_ON → S_HAZ_OFF
    - S_L3 → S_IDLE, left_sweeps+1
    - S_R3 → S_IDLE, right_sweeps+1
    - S_IDLE, S_BRAKE or S_HAZ_OFF → S_IDLE
    - S_L1, S_L2, S_R1 or S_R2 → S_IDLE with seq_err (truncated sweep)
  - Left step k: legal only from its predecessor (step1 from S_IDLE, step2 from S_L1, step3 from S_L2). Otherwise seq_err, and the state still resyncs to S_Lk.
  - Right steps: symmetric to left steps.
  - ALL:
    - S_IDLE → S_ALL
    - S_ALL, S_BRAKE or S_HAZ_ON → S_BRAKE
    - S_HAZ_OFF → S_HAZ_ON
    - any other state → S_ALL with seq_err
  - Illegal pattern: seq_err, → S_IDLE.
- Counters:
  - Saturate at 2^CNT_W-1.
  - err_count increments on every seq_err.
  - clr_counts=1 zeroes all three counters. It wins over a same-edge increment, but the state/seq_err update still occurs.

Test Plan:
- Reset=0 for 2 edges with tick=1 and lamps=111/111 → mode=0, seq_err=0, all counters 0.
- Left sweep OFF,001,011,111,OFF on consecutive ticks → mode 0,1,1,1,0; left_sweeps=1; err_count=0. Repeat ×3 → left_sweeps=4.
- Hazard ALL,OFF,ALL,OFF → mode 5,3,3,3, no errors. Then ALL,ALL → mode 4 (brake), err_count=0.
- Truncated left 001,011,OFF → seq_err pulse on the OFF sample, mode=0, err_count=1, left_sweeps unchanged. Then the illegal pattern 010/000 → err_count=2, mode=0.
- Out-of-order right: 000/011 directly from S_IDLE → seq_err, mode=2. Then 000/111, OFF → right_sweeps=1, err_count=1.
- Saturation and clear: with CNT_W=2, 5 illegal samples → err_count=3. clr_counts=1 on the same edge as an illegal sample → err_count=0, seq_err=1. Reset=0 mid-sweep (S_L2) → mode=0, no sweep counted.
